// File: rtl/aes_word_loader.sv
// aes_word_loader: 32-bit word stream to 128-bit key/state adapter around a
// fixed-latency pipelined AES-128 core. A token delay line follows each launch
// through the core. Results are captured into a first-word fall-through
// result FIFO. A credit counter throttles input so that no result is lost.
//
// Optional feature: define AES_KEY_REUSE_EN to add in_key_load. With it,
// a block may be 4 state words only, and it reuses the stored key.
module aes_word_loader #(
    parameter int LATENCY = 21,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
`ifdef AES_KEY_REUSE_EN
    input  logic         in_key_load,
`endif
    output logic [127:0] aes_state,
    output logic [127:0] aes_key,
    input  logic [127:0] aes_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [2:0]         wcnt;
    logic               long_blk;      // current block carries key words
    logic               cur_long;      // long_blk, or in_key_load on word 0
    logic [2:0]         last_pos;      // word index that completes the block
    logic               accept;
    logic               accept_last;
    logic               launch;
    logic [LATENCY-1:0] vpipe;
    logic               capture;
    logic               pop;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [127:0]       mem [DEPTH];

`ifdef AES_KEY_REUSE_EN
    assign cur_long = (wcnt == 3'd0) ? in_key_load : long_blk;

    // Latch the block length chosen by the first word of each block
    always_ff @(posedge clk) begin
        if (rst) begin
            long_blk <= 1'b1;
        end else if (accept && (wcnt == 3'd0)) begin
            long_blk <= in_key_load;
        end
    end
`else
    assign long_blk = 1'b1;
    assign cur_long = 1'b1;
`endif

    // Word 0 can never be the last word, so the latched length decides the
    // last position even while word 0 is still being presented.
    assign last_pos    = long_blk ? 3'd7 : 3'd3;
    assign in_ready    = (wcnt != last_pos) || (outstanding < DEPTH_C);
    assign accept      = in_valid && in_ready;
    assign accept_last = accept && (wcnt == last_pos);
    assign capture     = vpipe[LATENCY-1];
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    // Word counter: advance per accepted word, wrap after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= 3'd0;
        end else if (accept) begin
            wcnt <= accept_last ? 3'd0 : wcnt + 3'd1;
        end
    end

    // Scatter each accepted word into its 32-bit slice, most significant first
    always_ff @(posedge clk) begin
        if (rst) begin
            aes_key   <= '0;
            aes_state <= '0;
        end else if (accept) begin
            if (cur_long && !wcnt[2]) begin
                case (wcnt[1:0])
                    2'd0:    aes_key[127:96] <= in_data;
                    2'd1:    aes_key[95:64]  <= in_data;
                    2'd2:    aes_key[63:32]  <= in_data;
                    default: aes_key[31:0]   <= in_data;
                endcase
            end else begin
                case (wcnt[1:0])
                    2'd0:    aes_state[127:96] <= in_data;
                    2'd1:    aes_state[95:64]  <= in_data;
                    2'd2:    aes_state[63:32]  <= in_data;
                    default: aes_state[31:0]   <= in_data;
                endcase
            end
        end
    end

    // Launch pulse and token delay line that mirrors the core's latency
    always_ff @(posedge clk) begin
        if (rst) begin
            launch <= 1'b0;
            vpipe  <= '0;
        end else begin
            launch <= accept_last;
            vpipe  <= {vpipe[LATENCY-2:0], launch};
        end
    end

    // Credits: blocks launched or in flight or queued, released on pop
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept_last, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Result FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Result FIFO storage: the core output is written when its token arrives
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= aes_out;
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Testbench for aes_word_loader. Contains a behavioural AES-128 core with the
// same fixed latency and a block-level reference model of the loader.
module tb_aes_word_loader;

    localparam int LATENCY = 21;
    localparam int DEPTH   = 4;
    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZCT  = 128'hc6a13b37878f5b826f4f8162a1c8d879;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_key_load;
    logic [127:0] aes_state;
    logic [127:0] aes_key;
    logic [127:0] aes_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    always #5 clk = ~clk;

    aes_word_loader #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef AES_KEY_REUSE_EN
        .in_key_load(in_key_load),
`endif
        .aes_state(aes_state),
        .aes_key(aes_key),
        .aes_out(aes_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_entry(input int v);
        logic [7:0] b;
        logic [7:0] r;
        b = 8'(v);
        r = 8'h00;
        if (b != 8'h00) begin
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gmul(r, b);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    initial begin
        for (int v = 0; v < 256; v++) sbox[v] = sbox_entry(v);
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4*c+k];
                    s[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Pipelined core stand-in: computes every cycle, never stalls, never resets
    logic [127:0] core_pipe [LATENCY];
    assign aes_out = core_pipe[LATENCY-1];
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= aes_enc(aes_key, aes_state);
    end

    // ---------------- loader reference model ----------------
    typedef struct {
        logic [127:0] ct;
        int           ready;   // edge after which the result is visible
    } res_t;

    res_t         exp_q [$];
    logic [127:0] got_q [$];
    logic [31:0]  words [8];
    int           edge_n = 0;
    int           wpos = 0;
    logic         mlong = 1'b1;
    logic [127:0] mkey = '0;
    int           mout = 0;
    int           last_acc_edge = 0;
    int           pops = 0;
    bit           chk_en = 0;

    function automatic bit m_in_ready();
        int blen;
        blen = mlong ? 8 : 4;
        return (wpos != blen - 1) || (mout < DEPTH);
    endfunction

    always @(posedge clk) begin
        bit           ir;
        logic [127:0] k;
        logic [127:0] st;
        if (rst) begin
            wpos  = 0;
            mlong = 1'b1;
            mkey  = '0;
            mout  = 0;
            exp_q.delete();
        end else begin
            ir = m_in_ready();
            if (exp_q.size() > 0 && exp_q[0].ready <= edge_n && out_ready) begin
                void'(exp_q.pop_front());
                mout--;
            end
            if (in_valid && ir) begin
                if (wpos == 0) begin
`ifdef AES_KEY_REUSE_EN
                    mlong = in_key_load;
`else
                    mlong = 1'b1;
`endif
                end
                words[wpos] = in_data;
                wpos++;
                if (wpos == (mlong ? 8 : 4)) begin
                    if (mlong) begin
                        k  = {words[0], words[1], words[2], words[3]};
                        st = {words[4], words[5], words[6], words[7]};
                    end else begin
                        k  = mkey;
                        st = {words[0], words[1], words[2], words[3]};
                    end
                    mkey = k;
                    exp_q.push_back('{ct: aes_enc(k, st), ready: edge_n + 1 + LATENCY + 1});
                    mout++;
                    last_acc_edge = edge_n + 1;
                    wpos = 0;
                end
            end
        end
        edge_n++;
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        bit exp_ov;
        if (chk_en) begin
            exp_ov = (exp_q.size() > 0) && (exp_q[0].ready <= edge_n);
            check("in_ready", {127'd0, in_ready}, {127'd0, m_in_ready()});
            check("out_valid", {127'd0, out_valid}, {127'd0, exp_ov});
            if (exp_ov && out_valid) check("out_data", out_data, exp_q[0].ct);
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                pops++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic kl, input int max_gap);
        bit acc;
        int g;
        if (max_gap > 0) begin
            g = $urandom_range(max_gap, 0);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick(1);
            end
        end
        in_valid    = 1'b1;
        in_data     = d;
        in_key_load = kl;
        acc = 0;
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout: in_ready got 0, expected 1 within 400 cycles");
        end
    endtask

    task automatic send_block(input logic [127:0] key, input logic [127:0] pt,
                              input logic long_blk, input int max_gap);
        if (long_blk) begin
            for (int i = 0; i < 4; i++) send_word(key[127-32*i -: 32], long_blk, max_gap);
        end
        for (int i = 0; i < 4; i++) send_word(pt[127-32*i -: 32], long_blk, max_gap);
    endtask

    task automatic wait_drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while (!(exp_q.size() == 0 && mout == 0 && wpos == 0) && t < 400) begin
            tick(1);
            t++;
        end
        check("drain_done", {127'd0, (exp_q.size() == 0 && mout == 0)}, 128'd1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    bit bp_done;
    bit rnd_en;

    initial begin
        int           n_ov;
        int           first;
        int           p0;
        int           t;
        int           r4;
        logic [127:0] seen;
        logic [127:0] ek;
        logic [127:0] ep;
        logic         lb;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_key_load = 1'b1;
        out_ready = 1'b0;
        tick(3);

        // reset state
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_aes_state", aes_state, 128'd0);
        check("rst_aes_key", aes_key, 128'd0);
        rst = 1'b0;
        chk_en = 1;

        // pin the model to known FIPS-197 results
        check("model_fips", aes_enc(FKEY, FPT), FCT);
        check("model_zero_pt", aes_enc(FKEY, 128'd0), ZCT);

        // FIPS-197 vector with latency and single-assertion checks
        out_ready = 1'b1;
        send_block(FKEY, FPT, 1'b1, 0);
        n_ov = 0;
        first = -1;
        seen = '0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) begin
                n_ov++;
                if (first < 0) begin
                    first = edge_n;
                    seen = out_data;
                end
            end
        end
        tick(1);
        check("fips_ov_count", 128'(n_ov), 128'd1);
        check("fips_latency", 128'(first - last_acc_edge), 128'(LATENCY + 1));
        check("fips_data", seen, FCT);

        // back-pressure: six blocks with the consumer stalled
        out_ready = 1'b0;
        p0 = pops;
        bp_done = 0;
        fork
            begin
                for (int b = 0; b < 6; b++) send_block(rnd128(), rnd128(), 1'b1, 0);
                bp_done = 1;
            end
        join_none
        tick(70);
        check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        tick(20);
        check("bp_in_ready_still_low", {127'd0, in_ready}, 128'd0);
        check("bp_no_pops", 128'(pops - p0), 128'd0);
        out_ready = 1'b1;
        t = 0;
        while (!bp_done && t < 500) begin
            tick(1);
            t++;
        end
        check("bp_sender_done", {127'd0, bp_done}, 128'd1);
        wait_drain();
        check("bp_six_results", 128'(pops - p0), 128'd6);

        // pop coinciding with a capture
        out_ready = 1'b0;
        p0 = pops;
        for (int b = 0; b < 4; b++) send_block(rnd128(), rnd128(), 1'b1, 0);
        r4 = exp_q[exp_q.size()-1].ready;
        while (edge_n < r4 - 1) tick(1);
        check("pp_head_valid", {127'd0, out_valid}, 128'd1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        check("pp_after_valid", {127'd0, out_valid}, 128'd1);
        wait_drain();
        check("pp_four_results", 128'(pops - p0), 128'd4);

        // stalled input and random consumer back-pressure
        rnd_en = 1;
        fork
            begin
                while (rnd_en) begin
                    out_ready = 1'($urandom_range(1, 0));
                    tick(1);
                end
            end
        join_none
        p0 = pops;
        for (int b = 0; b < 8; b++) begin
`ifdef AES_KEY_REUSE_EN
            lb = (b == 0) ? 1'b1 : 1'($urandom_range(1, 0));
`else
            lb = 1'b1;
`endif
            send_block(rnd128(), rnd128(), lb, 3);
        end
        rnd_en = 0;
        tick(1);
        wait_drain();
        check("rand_result_count", 128'(pops - p0), 128'd8);

        // reset with one queued, two in flight and a partial block
        out_ready = 1'b0;
        send_block(rnd128(), rnd128(), 1'b1, 0);
        tick(LATENCY + 4);
        send_block(rnd128(), rnd128(), 1'b1, 0);
        send_block(rnd128(), rnd128(), 1'b1, 0);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b1, 0);
        check("pre_rst_valid", {127'd0, out_valid}, 128'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("mid_rst_aes_key", aes_key, 128'd0);
        p0 = pops;
        out_ready = 1'b1;
        tick(50);
        check("mid_rst_no_stale", 128'(pops - p0), 128'd0);
        ek = rnd128();
        ep = rnd128();
        send_block(ek, ep, 1'b1, 0);
        wait_drain();
        check("post_rst_result", got_q[got_q.size()-1], aes_enc(ek, ep));

`ifdef AES_KEY_REUSE_EN
        // key reuse: full block, then a state-only block
        out_ready = 1'b1;
        send_block(FKEY, FPT, 1'b1, 0);
        send_block(128'd0, 128'd0, 1'b0, 0);
        wait_drain();
        check("reuse_first", got_q[got_q.size()-2], FCT);
        check("reuse_second", got_q[got_q.size()-1], ZCT);
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
